// File: rtl/soc_system_sysid_checker_if.sv
// Avalon-MM read-only link between the sysid checker (master) and the sysid slave.
interface soc_system_sysid_checker_if;
  localparam int unsigned DATA_W = 32;

  logic              avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );
endinterface

// File: rtl/soc_system_sysid_checker.sv
// Reads sysid word 0 (ID) and word 1 (build timestamp) and compares them with the
// build-time constants; reports pass/fail, captured words and slave-hang timeouts.
module soc_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
  parameter logic [31:0] EXPECTED_TS    = 32'h56316AFA,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              start,
  soc_system_sysid_checker_if.master        avm,
  output logic                              busy,
  output logic                              done,
  output logic                              id_ok,
  output logic                              ts_ok,
  output logic                              timeout,
  output logic [31:0]                       id_value,
  output logic [31:0]                       ts_value
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DATA_W = 32;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_ID  = 3'd1,
    WAIT_ID = 3'd2,
    REQ_TS  = 3'd3,
    WAIT_TS = 3'd4,
    FINISH  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              auto_q, auto_d;
  logic              read_q, read_d;
  logic              addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              id_ok_q, id_ok_d;
  logic              ts_ok_q, ts_ok_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] id_value_q, id_value_d;
  logic [DATA_W-1:0] ts_value_q, ts_value_d;

  logic [CNT_W-1:0]  cnt_inc;
  logic              expire;

  // Per-read budget covers both the request and the response wait.
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign expire  = (cnt_inc >= CNT_LAST);

  // State register and all registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      auto_q     <= AUTO_START;
      read_q     <= 1'b0;
      addr_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      auto_q     <= auto_d;
      read_q     <= read_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  // Next-state logic; responses seen in REQ_* or IDLE are deliberately ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    auto_d  = auto_q;
    unique case (state_q)
      IDLE: begin
        if (start || auto_q) begin
          state_d = REQ_ID;
          cnt_d   = '0;
          auto_d  = 1'b0;
        end
      end
      REQ_ID: begin
        cnt_d = cnt_inc;
        if (!avm.avm_waitrequest) state_d = WAIT_ID;
        else if (expire)          state_d = FINISH;
      end
      WAIT_ID: begin
        cnt_d = cnt_inc;
        if (avm.avm_readdatavalid) begin
          state_d = REQ_TS;
          cnt_d   = '0;
        end else if (expire) begin
          state_d = FINISH;
        end
      end
      REQ_TS: begin
        cnt_d = cnt_inc;
        if (!avm.avm_waitrequest) state_d = WAIT_TS;
        else if (expire)          state_d = FINISH;
      end
      WAIT_TS: begin
        cnt_d = cnt_inc;
        if (avm.avm_readdatavalid || expire) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: registered versions of the decoded next state plus captures.
  always_comb begin
    read_d     = (state_d == REQ_ID) || (state_d == REQ_TS);
    addr_d     = (state_d == REQ_TS);
    busy_d     = busy_q;
    done_d     = 1'b0;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    unique case (state_q)
      IDLE: begin
        if (state_d == REQ_ID) begin
          busy_d     = 1'b1;
          id_ok_d    = 1'b0;
          ts_ok_d    = 1'b0;
          timeout_d  = 1'b0;
          id_value_d = '0;
          ts_value_d = '0;
        end
      end
      WAIT_ID: begin
        if (avm.avm_readdatavalid) begin
          id_value_d = avm.avm_readdata;
          id_ok_d    = (avm.avm_readdata == EXPECTED_ID);
        end
      end
      WAIT_TS: begin
        if (avm.avm_readdatavalid) begin
          ts_value_d = avm.avm_readdata;
          ts_ok_d    = (avm.avm_readdata == EXPECTED_TS);
        end
      end
      FINISH: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
    // Any exit to FINISH other than the timestamp response is an abort.
    if ((state_d == FINISH) && !((state_q == WAIT_TS) && avm.avm_readdatavalid)) begin
      timeout_d = 1'b1;
    end
  end

  assign avm.avm_read    = read_q;
  assign avm.avm_address = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign id_ok           = id_ok_q;
  assign ts_ok           = ts_ok_q;
  assign timeout         = timeout_q;
  assign id_value        = id_value_q;
  assign ts_value        = ts_value_q;

endmodule

// File: doc/soc_system_sysid_checker.md
Name: soc_system_sysid_checker

Overview:
- Avalon-MM read master (initiator) that queries the system-ID slave after reset or on request, and compares both words against build-time expected values.
- Sits between the HPS-side boot/status logic and the sysid control slave. Gives hardware a single pass/fail flag showing that the loaded FPGA image matches the software build.
- Also used as a bring-up aid on the fabric interconnect: it reports the values it read back and flags a hung slave through a timeout.

Parameters:
- EXPECTED_ID, 32'hACD51302, required system ID returned at word address 0.
- EXPECTED_TS, 32'h56316AFA, required build timestamp returned at word address 1.
- TIMEOUT_CYCLES, 1024, maximum clocks allowed per read from read asserted to readdatavalid; range 2..65535.
- AUTO_START, 1, 1 = run one check automatically after reset deasserts.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse requesting a check; ignored while busy
- avm_address  out  1  word address to sysid slave (0 = ID, 1 = timestamp)
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall; the request is held while this is high
- avm_readdata  in  32  read data, valid when avm_readdatavalid = 1
- avm_readdatavalid  in  1  read response strobe
- busy  out  1  check in progress
- done  out  1  one-cycle pulse when a check finishes (pass, fail or timeout)
- id_ok  out  1  last ID read equalled EXPECTED_ID
- ts_ok  out  1  last timestamp read equalled EXPECTED_TS
- timeout  out  1  last check aborted by timeout
- id_value  out  32  last captured ID word
- ts_value  out  32  last captured timestamp word

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - FSM goes to IDLE.
  - All outputs are 0: avm_read, avm_address, busy, done, id_ok, ts_ok, timeout, id_value, ts_value.
  - Timeout counter is cleared.
  - A pending auto-start flag is set to AUTO_START.
- FSM states are IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, FINISH.
- IDLE:
  - Leaves to REQ_ID when start = 1 or the auto-start flag is set.
  - The auto-start flag clears on leaving IDLE.
  - On entry to REQ_ID: clear id_ok, ts_ok and timeout, and set busy = 1.
- REQ_ID:
  - Drives avm_read = 1 and avm_address = 0.
  - Address and read stay stable while avm_waitrequest = 1.
  - The read is accepted on the first cycle with avm_waitrequest = 0; the FSM then moves to WAIT_ID and deasserts avm_read the next cycle.
- WAIT_ID:
  - On avm_readdatavalid = 1, capture id_value = avm_readdata and id_ok = (avm_readdata == EXPECTED_ID), then go to REQ_TS.
- REQ_TS and WAIT_TS behave the same as REQ_ID and WAIT_ID, but with avm_address = 1 and the capture going to ts_value and ts_ok. WAIT_TS goes to FINISH.
- FINISH lasts one cycle:
  - done = 1 and busy = 0 on the following cycle.
  - Returns to IDLE.
- Flags and captured values hold until the next check starts.
- Latency with a zero-wait, 1-cycle-latency slave: start seen in cycle 0 → done pulse in cycle 6.
- Pipelining: no pipelining; at most one outstanding read.
  - readdatavalid in REQ_* or IDLE is ignored.
  - readdatavalid in the same cycle as acceptance is not legal for this slave, and is ignored.
- Timeout:
  - Counter is cleared on entry to REQ_ID and REQ_TS, and increments every cycle in REQ_* and WAIT_*.
  - When it reaches TIMEOUT_CYCLES-1 without the matching readdatavalid, set timeout = 1, drop avm_read and go to FINISH.
  - The flag for the word not read (and, if the ID timed out, ts_ok) stays 0; id_value/ts_value for words not read stay 0.
- A start pulse while busy = 1 is dropped, with no queueing.
- If start and the auto-start flag are both set in IDLE, only one check runs.
- reset_n asserted mid-transaction aborts immediately; avm_read drops asynchronously. A late readdatavalid after reset is ignored because the FSM is in IDLE.
- Comparison is a full 32-bit equality with no masking.

Test Plan:
- Auto-start, zero-wait slave returning 0xACD51302 / 0x56316AFA:
  - Read order is address 0 then 1.
  - done pulses once, with id_ok = ts_ok = 1 and timeout = 0.
  - id_value and ts_value equal the returned words.
- start pulse, slave returns ID 0xACD51302 and TS 0x00000000 → id_ok = 1, ts_ok = 0, ts_value = 0.
- Slave holds waitrequest for 5 cycles on each read → avm_address and avm_read are stable throughout, exactly two reads are accepted, and the result passes.
- TIMEOUT_CYCLES = 8, slave never asserts readdatavalid on the ID read:
  - timeout = 1 and done pulses 8 cycles after the read is asserted.
  - id_ok = ts_ok = 0 and avm_read = 0.
  - No timestamp read is issued.
- start pulses while busy, and start coincident with auto-start → exactly one check and one done pulse per IDLE exit.
- reset_n low during WAIT_TS, then a late readdatavalid → all outputs 0, the readdatavalid is ignored, and an auto-start check reruns cleanly after release.
